qvalue_writer: RTL

- Write-side companion to the reward block on the shared node memory: reward reads neighbor/Q tables, qvalue_writer writes updated Q-values back.
- On start, it latches a neighbor ID (action) and a new Q-value, and searches the neighborID table (base 0x48, 16-bit entries, stride 2) for the lowest matching slot.
- If it finds a match, it writes the Q-value into the matching qValue slot (base 0x1C8).
- It shares the memory port (address / wr_en / data) with the learning datapath.

---
 rtl/qvalue_writer_if.sv | 24 ++
 rtl/qvalue_writer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/qvalue_writer_if.sv
// Shared node-memory port: byte address, write strobe and data in both directions.
// The writer drives the address/write side and reads back one clock after the address.
interface qvalue_writer_if #(
   parameter int WORD_WIDTH = 16
);
   logic [WORD_WIDTH-1:0] address;
   logic                  wr_en;
   logic [WORD_WIDTH-1:0] mem_data_in;
   logic [WORD_WIDTH-1:0] mem_data_out;

   modport master (
      output address,
      output wr_en,
      output mem_data_in,
      input  mem_data_out
   );

   modport slave (
      input  address,
      input  wr_en,
      input  mem_data_in,
      output mem_data_out
   );
endinterface

// File: rtl/qvalue_writer.sv
// Searches the neighborID table for the lowest slot holding action_id and writes
// new_qvalue into the matching qValue slot of the shared node memory.
module qvalue_writer #(
   parameter int                     WORD_WIDTH    = 16,
   parameter logic [WORD_WIDTH-1:0]  NEIGHBOR_BASE = 16'h0048,
   parameter logic [WORD_WIDTH-1:0]  QVALUE_BASE   = 16'h01C8,
   parameter int                     MAX_NEIGHBORS = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] action_id,
   input  logic [WORD_WIDTH-1:0] new_qvalue,
   input  logic [6:0]            neighbor_count,
   output logic [5:0]            slot,
   output logic                  found,
   output logic                  done,
   qvalue_writer_if.master       mem
);

   localparam logic [6:0] MAX_CNT = 7'(MAX_NEIGHBORS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      CHECK = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            idx_q, idx_d;
   logic [6:0]            count_q, count_d;
   logic [WORD_WIDTH-1:0] action_q, action_d;
   logic [WORD_WIDTH-1:0] qvalue_q, qvalue_d;
   logic [WORD_WIDTH-1:0] address_q, address_d;
   logic                  wr_en_q, wr_en_d;
   logic [WORD_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
   logic [5:0]            slot_q, slot_d;
   logic                  found_q, found_d;
   logic                  done_q, done_d;

   logic [6:0]            count_clamped;
   logic [6:0]            idx_plus_one;
   logic [5:0]            idx_next;

   // Byte offset of a 16-bit table entry: index shifted left by one.
   function automatic logic [WORD_WIDTH-1:0] entry_offset(input logic [5:0] index);
      return {{(WORD_WIDTH-7){1'b0}}, index, 1'b0};
   endfunction

   assign count_clamped = (neighbor_count > MAX_CNT) ? MAX_CNT : neighbor_count;
   assign idx_plus_one  = {1'b0, idx_q} + 7'd1;
   assign idx_next      = idx_q + 6'd1;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      count_d       = count_q;
      action_d      = action_q;
      qvalue_d      = qvalue_q;
      address_d     = address_q;
      wr_en_d       = wr_en_q;
      mem_data_in_d = mem_data_in_q;
      slot_d        = slot_q;
      found_d       = found_q;
      done_d        = done_q;

      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  action_d = action_id;
                  qvalue_d = new_qvalue;
                  count_d  = count_clamped;
                  idx_d    = '0;
                  found_d  = 1'b0;
                  slot_d   = '0;
                  if (count_clamped == 7'd0) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     // Address is presented for the whole FETCH cycle so the
                     // memory's registered read is ready by CHECK.
                     address_d = NEIGHBOR_BASE;
                     state_d   = FETCH;
                  end
               end
            end
            FETCH: begin
               state_d = CHECK;
            end
            CHECK: begin
               if (mem.mem_data_out == action_q) begin
                  slot_d        = idx_q;
                  found_d       = 1'b1;
                  address_d     = QVALUE_BASE + entry_offset(idx_q);
                  mem_data_in_d = qvalue_q;
                  wr_en_d       = 1'b1;
                  state_d       = WRITE;
               end else if (idx_plus_one == count_q) begin
                  found_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  idx_d     = idx_next;
                  address_d = NEIGHBOR_BASE + entry_offset(idx_next);
                  state_d   = FETCH;
               end
            end
            WRITE: begin
               wr_en_d = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
            DONE: begin
               if (!start) begin
                  done_d  = 1'b0;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         count_q       <= '0;
         action_q      <= '0;
         qvalue_q      <= '0;
         address_q     <= '0;
         wr_en_q       <= 1'b0;
         mem_data_in_q <= '0;
         slot_q        <= '0;
         found_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         count_q       <= count_d;
         action_q      <= action_d;
         qvalue_q      <= qvalue_d;
         address_q     <= address_d;
         wr_en_q       <= wr_en_d;
         mem_data_in_q <= mem_data_in_d;
         slot_q        <= slot_d;
         found_q       <= found_d;
         done_q        <= done_d;
      end
   end

   // Gating with en stalls the strobe so a frozen WRITE cycle never commits early.
   assign mem.wr_en       = wr_en_q & en;
   assign mem.address     = address_q;
   assign mem.mem_data_in = mem_data_in_q;
   assign slot            = slot_q;
   assign found           = found_q;
   assign done            = done_q;

endmodule
